output_unit_rr: RTL and testbench
=================================

Name: output_unit_rr

Overview:
- Parametrised next-generation router output port.
- Arbitrates round-robin among NUM_IN switch requesters and locks the winner for a whole wormhole packet.
- Buffers accepted flits in a DEPTH-entry output FIFO and drives the downstream link with a req/ack handshake.
- Sits between the switch allocator/crossbar and the link to the neighbouring router.

Parameters:
- NUM_IN, 5, number of input ports that may request this output.
- FLIT_W, 34, flit width. Bits [FLIT_W-1:FLIT_W-2] are the flit type: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 HEADTAIL (single-flit packet).
- DEPTH, 4, output FIFO entries; power of two, >=2.
- CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_req  in  NUM_IN  per-input switch request; a flit is presented on that input's lane.
- i_flit  in  NUM_IN*FLIT_W  input lanes; lane i is bits [i*FLIT_W +: FLIT_W].
- o_ack  out  NUM_IN  one-hot, combinational; lane i's flit is consumed this cycle.
- o_ds_req  out  1  downstream request; FIFO not empty.
- o_ds_flit  out  FLIT_W  FIFO head flit.
- i_ds_ack  in  1  downstream accepts o_ds_flit this cycle.
- o_owner  out  NUM_IN  one-hot current packet owner; 0 when free.
- o_port_status  out  2  2'b00 FREE, 2'b01 BUSY, 2'b10 STALLED.
- o_occupancy  out  $clog2(DEPTH)+1  FIFO entry count.
- o_proto_err  out  1  sticky protocol-error flag.
- o_flit_cnt  out  CNT_W  flits sent downstream (optional feature).
- o_stall_cnt  out  CNT_W  downstream stall cycles (optional feature).

Behaviour:
- Reset:
  - Sampled on a clk edge. All registers clear: FSM=IDLE, rr_ptr=0, FIFO empty.
  - Outputs after reset: o_ds_req=0, o_ds_flit=0, o_owner=0, o_port_status=FREE, o_occupancy=0, o_proto_err=0, counters=0.
  - o_ack=0 while reset is high.
  - Reset mid-packet discards the lock and all buffered flits with no flush to downstream.
- FSM IDLE:
  - Eligible inputs: i_req[i]=1 and the lane type is HEAD or HEADTAIL.
  - If any input is eligible and the FIFO is not full, grant the first eligible input at or after rr_ptr, searching cyclically.
  - On grant: assert o_ack[grant], push the flit, set rr_ptr=grant+1 mod NUM_IN.
  - Grant of a HEAD: owner=grant, go to LOCKED.
  - Grant of a HEADTAIL: stay IDLE, owner stays 0.
  - If the FIFO is full: no grant, no ack, state unchanged.
- FSM LOCKED:
  - Only the owner is served; all other requests get no ack.
  - If i_req[owner]=1 and the FIFO is not full: o_ack[owner]=1 and push.
  - A pushed TAIL clears owner and returns to IDLE; the next arbitration can occur the following cycle.
  - HEAD or HEADTAIL from the owner while LOCKED: accepted as a body flit and sets o_proto_err.
- Protocol error in IDLE: i_req with a BODY or TAIL lane is never acked and sets o_proto_err. o_proto_err clears only on reset.
- FIFO:
  - Full means occupancy==DEPTH; push is blocked when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full or not empty leaves occupancy unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Latency: a flit acked at edge t is on o_ds_flit with o_ds_req=1 after edge t+1, when the FIFO was empty.
- Downstream handshake:
  - Transfer occurs when o_ds_req & i_ds_ack, and pops the FIFO.
  - o_ds_flit is stable while o_ds_req=1 and i_ds_ack=0.
  - i_ds_ack while the FIFO is empty is ignored.
- Status (registered outputs derived from next state):
  - STALLED: owner!=0 and i_req[owner]=1 and FIFO full.
  - BUSY: otherwise, when owner!=0.
  - FREE: otherwise.
- Ordering: flits leave in acceptance order; packets from different inputs never interleave.

Optional Feature:
- Macro: OUTPUT_UNIT_PERF_CNT_EN.
- Defined:
  - o_flit_cnt increments on each downstream transfer.
  - o_stall_cnt increments each cycle with o_ds_req=1 and i_ds_ack=0.
  - Both saturate at 2^CNT_W-1 and clear on reset.
- Undefined: no counter registers; o_flit_cnt and o_stall_cnt are tied to 0.

Test Plan:
- Single packet (NUM_IN=5, DEPTH=4), i_ds_ack=1:
  - Stimulus: input 2 sends HEAD, BODY, TAIL on consecutive cycles.
  - Response: o_ack[2] on 3 cycles; o_owner=5'b00100 until the TAIL cycle, then 0; o_ds_req high for 3 cycles starting one cycle after the first ack; flits in order.
- Round-robin fairness:
  - Stimulus: inputs 0, 1 and 4 all hold HEADTAIL requests from reset, i_ds_ack=1.
  - Response: grant order 0, 1, 4, 0, 1, 4.
- Packet lock:
  - Stimulus: input 1 holds a 4-flit packet while input 3 requests a HEAD.
  - Response: input 3 gets no ack until the cycle after input 1's TAIL is accepted, then input 3 is granted.
- Back-pressure:
  - Stimulus: i_ds_ack=0, input 0 streams a 6-flit packet.
  - Response: 4 acks, then o_occupancy=4 and o_port_status=STALLED; o_ds_flit holds the HEAD.
  - Follow-up: release i_ds_ack; all 6 flits are delivered in order and the status returns to FREE.
- Protocol error:
  - Stimulus: in IDLE, input 2 requests with a BODY lane.
  - Response: no ack; o_proto_err=1 from the next cycle and stays set until reset.
- Reset mid-packet:
  - Stimulus: assert reset for 1 cycle with 3 flits buffered and the lock held.
  - Response: after the edge o_ds_req=0, o_occupancy=0, o_owner=0.
  - With OUTPUT_UNIT_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/output_unit_rr.sv
// Router output port: round-robin switch arbitration with wormhole packet lock, DEPTH-entry
// output FIFO and req/ack downstream link. Define OUTPUT_UNIT_PERF_CNT_EN for saturating flit/stall counters.
module output_unit_rr #(
  parameter int NUM_IN = 5,
  parameter int FLIT_W = 34,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        i_req,
  input  logic [NUM_IN*FLIT_W-1:0] i_flit,
  output logic [NUM_IN-1:0]        o_ack,
  output logic                     o_ds_req,
  output logic [FLIT_W-1:0]        o_ds_flit,
  input  logic                     i_ds_ack,
  output logic [NUM_IN-1:0]        o_owner,
  output logic [1:0]               o_port_status,
  output logic [$clog2(DEPTH):0]   o_occupancy,
  output logic                     o_proto_err,
  output logic [CNT_W-1:0]         o_flit_cnt,
  output logic [CNT_W-1:0]         o_stall_cnt
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [1:0] TYPE_HEAD     = 2'b10;
  localparam logic [1:0] TYPE_TAIL     = 2'b01;
  localparam logic [1:0] TYPE_HEADTAIL = 2'b11;

  localparam logic [1:0] STATUS_FREE    = 2'b00;
  localparam logic [1:0] STATUS_BUSY    = 2'b01;
  localparam logic [1:0] STATUS_STALLED = 2'b10;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] flit);
    return flit[FLIT_W-1 -: 2];
  endfunction

  function automatic logic opens_packet(input logic [1:0] ftype);
    return (ftype == TYPE_HEAD) || (ftype == TYPE_HEADTAIL);
  endfunction

  state_t              state_r, state_next_s;
  logic [NUM_IN-1:0]   owner_r, owner_next_s;
  logic [IDX_W-1:0]    owner_idx_r, owner_idx_next_s;
  logic [IDX_W-1:0]    rr_ptr_r, rr_ptr_next_s, grant_s;
  logic [IDX_W:0]      cand_s;
  logic                found_s;
  logic                proto_err_r, proto_err_next_s;
  logic [1:0]          status_r, status_next_s;
  logic [FLIT_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [OCC_W-1:0]    count_r, count_next_s;
  logic [NUM_IN-1:0]   ack_s, elig_s, bad_req_s;
  logic                push_s, pop_s, full_s, ds_req_s;
  logic [FLIT_W-1:0]   push_flit_s;
  logic [FLIT_W-1:0]   lane_s [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    assign lane_s[g]    = i_flit[g*FLIT_W +: FLIT_W];
    assign elig_s[g]    = i_req[g] & opens_packet(flit_type(lane_s[g]));
    assign bad_req_s[g] = i_req[g] & ~opens_packet(flit_type(lane_s[g]));
  end

  assign ds_req_s = (count_r != '0);
  assign full_s   = (count_r == OCC_W'(DEPTH));
  assign pop_s    = ds_req_s & i_ds_ack;

  // Arbitration, packet lock and protocol-error detection
  always_comb begin
    ack_s            = '0;
    push_s           = 1'b0;
    push_flit_s      = '0;
    grant_s          = '0;
    found_s          = 1'b0;
    cand_s           = '0;
    state_next_s     = state_r;
    owner_next_s     = owner_r;
    owner_idx_next_s = owner_idx_r;
    rr_ptr_next_s    = rr_ptr_r;
    proto_err_next_s = proto_err_r;
    if (reset) begin
      ack_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // cyclic search for the first eligible requester at or after rr_ptr
          for (int k = 0; k < NUM_IN; k++) begin
            cand_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
            if (cand_s >= (IDX_W+1)'(NUM_IN)) begin
              cand_s = cand_s - (IDX_W+1)'(NUM_IN);
            end else begin
              cand_s = cand_s;
            end
            if (!found_s && elig_s[cand_s[IDX_W-1:0]]) begin
              found_s = 1'b1;
              grant_s = cand_s[IDX_W-1:0];
            end else begin
              found_s = found_s;
            end
          end
          if (found_s && !full_s) begin
            ack_s[grant_s] = 1'b1;
            push_s         = 1'b1;
            push_flit_s    = lane_s[grant_s];
            rr_ptr_next_s  = (grant_s == IDX_W'(NUM_IN - 1)) ? '0 : grant_s + IDX_W'(1);
            if (flit_type(lane_s[grant_s]) == TYPE_HEAD) begin
              state_next_s     = ST_LOCKED;
              owner_next_s     = NUM_IN'(1) << grant_s;
              owner_idx_next_s = grant_s;
            end else begin
              state_next_s = ST_IDLE;
            end
          end else begin
            push_s = 1'b0;
          end
          if (|bad_req_s) begin
            proto_err_next_s = 1'b1;
          end else begin
            proto_err_next_s = proto_err_r;
          end
        end
        ST_LOCKED: begin
          if (i_req[owner_idx_r] && !full_s) begin
            ack_s[owner_idx_r] = 1'b1;
            push_s             = 1'b1;
            push_flit_s        = lane_s[owner_idx_r];
            if (flit_type(lane_s[owner_idx_r]) == TYPE_TAIL) begin
              state_next_s     = ST_IDLE;
              owner_next_s     = '0;
              owner_idx_next_s = '0;
            end else if (opens_packet(flit_type(lane_s[owner_idx_r]))) begin
              proto_err_next_s = 1'b1;
            end else begin
              state_next_s = ST_LOCKED;
            end
          end else begin
            push_s = 1'b0;
          end
        end
        default: begin
          state_next_s     = ST_IDLE;
          owner_next_s     = '0;
          owner_idx_next_s = '0;
        end
      endcase
    end
  end

  // Next occupancy and next port status
  always_comb begin
    count_next_s  = count_r;
    status_next_s = STATUS_FREE;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + OCC_W'(1);
      2'b01:   count_next_s = count_r - OCC_W'(1);
      default: count_next_s = count_r;
    endcase
    if ((owner_next_s != '0) && ((i_req & owner_next_s) != '0) &&
        (count_next_s == OCC_W'(DEPTH))) begin
      status_next_s = STATUS_STALLED;
    end else if (owner_next_s != '0) begin
      status_next_s = STATUS_BUSY;
    end else begin
      status_next_s = STATUS_FREE;
    end
  end

  // Control, status and FIFO pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      owner_r     <= '0;
      owner_idx_r <= '0;
      rr_ptr_r    <= '0;
      proto_err_r <= 1'b0;
      status_r    <= STATUS_FREE;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
    end else begin
      state_r     <= state_next_s;
      owner_r     <= owner_next_s;
      owner_idx_r <= owner_idx_next_s;
      rr_ptr_r    <= rr_ptr_next_s;
      proto_err_r <= proto_err_next_s;
      status_r    <= status_next_s;
      count_r     <= count_next_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
    end
  end

  // FIFO storage; contents are don't-care while empty since the output is masked
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= push_flit_s;
  end

  assign o_ack         = ack_s;
  assign o_ds_req      = ds_req_s;
  assign o_ds_flit     = ds_req_s ? mem_r[rd_ptr_r] : '0;
  assign o_owner       = owner_r;
  assign o_port_status = status_r;
  assign o_occupancy   = count_r;
  assign o_proto_err   = proto_err_r;

`ifdef OUTPUT_UNIT_PERF_CNT_EN
  logic [CNT_W-1:0] flit_cnt_r, stall_cnt_r;

  // Saturating transfer and stall counters
  always_ff @(posedge clk) begin
    if (reset) begin
      flit_cnt_r  <= '0;
      stall_cnt_r <= '0;
    end else begin
      if (pop_s && (flit_cnt_r != {CNT_W{1'b1}})) flit_cnt_r <= flit_cnt_r + CNT_W'(1);
      if (ds_req_s && !i_ds_ack && (stall_cnt_r != {CNT_W{1'b1}}))
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end
  end

  assign o_flit_cnt  = flit_cnt_r;
  assign o_stall_cnt = stall_cnt_r;
`else
  assign o_flit_cnt  = '0;
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_output_unit_rr.sv
// Self-checking bench for output_unit_rr: directed vector table, hand-written corner sequences
// and randomized traffic, all compared against a queue-based packet-level reference model.
module tb_output_unit_rr;
  localparam int NUM_IN = 5;
  localparam int FLIT_W = 34;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam logic [1:0] HD = 2'b10, BD = 2'b00, TL = 2'b01, HT = 2'b11;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_IN-1:0]        i_req;
  logic [NUM_IN*FLIT_W-1:0] i_flit;
  logic [NUM_IN-1:0]        o_ack;
  logic                     o_ds_req;
  logic [FLIT_W-1:0]        o_ds_flit;
  logic                     i_ds_ack;
  logic [NUM_IN-1:0]        o_owner;
  logic [1:0]               o_port_status;
  logic [$clog2(DEPTH):0]   o_occupancy;
  logic                     o_proto_err;
  logic [CNT_W-1:0]         o_flit_cnt;
  logic [CNT_W-1:0]         o_stall_cnt;

  output_unit_rr #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_flit(i_flit), .o_ack(o_ack),
    .o_ds_req(o_ds_req), .o_ds_flit(o_ds_flit), .i_ds_ack(i_ds_ack), .o_owner(o_owner),
    .o_port_status(o_port_status), .o_occupancy(o_occupancy), .o_proto_err(o_proto_err),
    .o_flit_cnt(o_flit_cnt), .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int seq = 0;

  // ---------------- reference model (packet level) ----------------
  int                m_owner;   // -1 when no packet holds the port
  int                m_rr;
  int                m_grant;   // winner for the current cycle, -1 if none
  int                m_fc, m_sc;
  bit                m_err;
  logic [1:0]        m_status;
  logic [FLIT_W-1:0] m_q [$];

  function automatic logic [FLIT_W-1:0] lane(int i);
    return i_flit[i*FLIT_W +: FLIT_W];
  endfunction

  function automatic logic [1:0] ltype(int i);
    logic [FLIT_W-1:0] f;
    f = lane(i);
    return f[FLIT_W-1 -: 2];
  endfunction

  function automatic logic [FLIT_W-1:0] make_flit(logic [1:0] t, int ln, int s);
    return {t, 8'(ln), 24'(s)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_grant = -1; m_fc = 0; m_sc = 0;
    m_err = 1'b0; m_status = 2'b00; m_q.delete();
  endtask

  task automatic model_predict();
    logic [1:0] t;
    m_grant = -1;
    if (!reset && m_q.size() < DEPTH) begin
      if (m_owner < 0) begin
        for (int k = 0; k < NUM_IN; k++) begin
          int i;
          i = (m_rr + k) % NUM_IN;
          t = ltype(i);
          if (m_grant < 0 && i_req[i] && (t == HD || t == HT)) m_grant = i;
        end
      end else if (i_req[m_owner]) begin
        m_grant = m_owner;
      end
    end
  endtask

  task automatic model_update();
    logic [1:0] t;
    bit was_free;
    if (reset) begin
      model_reset();
      return;
    end
    was_free = (m_owner < 0);
    if (m_q.size() > 0) begin
      if (i_ds_ack) begin
        void'(m_q.pop_front());
        if (m_fc < (1 << CNT_W) - 1) m_fc++;
      end else if (m_sc < (1 << CNT_W) - 1) begin
        m_sc++;
      end
    end
    if (was_free) begin
      for (int i = 0; i < NUM_IN; i++) begin
        t = ltype(i);
        if (i_req[i] && (t == BD || t == TL)) m_err = 1'b1;
      end
    end
    if (m_grant >= 0) begin
      m_q.push_back(lane(m_grant));
      t = ltype(m_grant);
      if (was_free) begin
        m_rr = (m_grant + 1) % NUM_IN;
        if (t == HD) m_owner = m_grant;
      end else if (t == TL) begin
        m_owner = -1;
      end else if (t == HD || t == HT) begin
        m_err = 1'b1;
      end
    end
    if (m_owner >= 0 && i_req[m_owner] && m_q.size() == DEPTH) m_status = 2'b10;
    else if (m_owner >= 0) m_status = 2'b01;
    else m_status = 2'b00;
  endtask

  task automatic model_check();
    logic [NUM_IN-1:0] e_ack, e_own;
    logic [FLIT_W-1:0] e_flit;
    e_ack  = (m_grant < 0) ? '0 : NUM_IN'(1) << m_grant;
    e_own  = (m_owner < 0) ? '0 : NUM_IN'(1) << m_owner;
    e_flit = (m_q.size() > 0) ? m_q[0] : '0;
    chk("m_ack",    64'(o_ack),         64'(e_ack));
    chk("m_owner",  64'(o_owner),       64'(e_own));
    chk("m_ds_req", 64'(o_ds_req),      64'(m_q.size() > 0));
    chk("m_ds_flit",64'(o_ds_flit),     64'(e_flit));
    chk("m_occ",    64'(o_occupancy),   64'(m_q.size()));
    chk("m_status", 64'(o_port_status), 64'(m_status));
    chk("m_err",    64'(o_proto_err),   64'(m_err));
`ifdef OUTPUT_UNIT_PERF_CNT_EN
    chk("m_flit_cnt",  64'(o_flit_cnt),  64'(m_fc));
    chk("m_stall_cnt", 64'(o_stall_cnt), 64'(m_sc));
`else
    chk("m_flit_cnt",  64'(o_flit_cnt),  64'd0);
    chk("m_stall_cnt", 64'(o_stall_cnt), 64'd0);
`endif
  endtask

  task automatic set_lanes(input logic [9:0] types);
    for (int i = 0; i < NUM_IN; i++) begin
      i_flit[i*FLIT_W +: FLIT_W] = make_flit(types[2*i +: 2], i, seq);
      seq++;
    end
  endtask

  task automatic settle();
    #1;
    model_predict();
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic drive(input logic rst, input logic [4:0] req, input logic [9:0] types,
                       input logic ds_ack);
    @(negedge clk);
    reset = rst; i_req = req; i_ds_ack = ds_ack;
    set_lanes(types);
    settle();
  endtask

  task automatic do_reset();
    drive(1'b1, 5'b0, 10'b0, 1'b0);
    tick();
  endtask

  typedef struct {
    logic       rst;
    logic [4:0] req;
    logic [9:0] types;   // lane i type at [2i+1:2i]
    logic       ds_ack;
    logic [4:0] exp_ack;
    logic [4:0] exp_owner;
    logic       exp_ds_req;
    logic [2:0] exp_occ;
    logic       exp_err;
  } vec_t;

  vec_t tv [17];
  logic [FLIT_W-1:0] sent [6];
  logic [FLIT_W-1:0] got [$];
  logic [1:0] bp_t [6];
  logic [4:0] lk_req [6];
  logic [9:0] lk_ty [6];
  logic [4:0] lk_ack [6];
  int idx;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // single packet on input 2
    tv[0]  = '{1'b0, 5'b00100, 10'b00_00_10_00_00, 1'b1, 5'b00100, 5'b00000, 1'b0, 3'd0, 1'b0};
    tv[1]  = '{1'b0, 5'b00100, 10'b00_00_00_00_00, 1'b1, 5'b00100, 5'b00100, 1'b1, 3'd1, 1'b0};
    tv[2]  = '{1'b0, 5'b00100, 10'b00_00_01_00_00, 1'b1, 5'b00100, 5'b00100, 1'b1, 3'd1, 1'b0};
    tv[3]  = '{1'b0, 5'b00000, 10'b0,              1'b1, 5'b00000, 5'b00000, 1'b1, 3'd1, 1'b0};
    tv[4]  = '{1'b0, 5'b00000, 10'b0,              1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0};
    // reset, then HEADTAIL requests from inputs 0, 1 and 4
    tv[5]  = '{1'b1, 5'b00000, 10'b0,              1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0};
    tv[6]  = '{1'b0, 5'b10011, 10'b11_00_00_11_11, 1'b1, 5'b00001, 5'b00000, 1'b0, 3'd0, 1'b0};
    tv[7]  = '{1'b0, 5'b10011, 10'b11_00_00_11_11, 1'b1, 5'b00010, 5'b00000, 1'b1, 3'd1, 1'b0};
    tv[8]  = '{1'b0, 5'b10011, 10'b11_00_00_11_11, 1'b1, 5'b10000, 5'b00000, 1'b1, 3'd1, 1'b0};
    tv[9]  = '{1'b0, 5'b10011, 10'b11_00_00_11_11, 1'b1, 5'b00001, 5'b00000, 1'b1, 3'd1, 1'b0};
    tv[10] = '{1'b0, 5'b10011, 10'b11_00_00_11_11, 1'b1, 5'b00010, 5'b00000, 1'b1, 3'd1, 1'b0};
    tv[11] = '{1'b0, 5'b10011, 10'b11_00_00_11_11, 1'b1, 5'b10000, 5'b00000, 1'b1, 3'd1, 1'b0};
    tv[12] = '{1'b0, 5'b00000, 10'b0,              1'b1, 5'b00000, 5'b00000, 1'b1, 3'd1, 1'b0};
    tv[13] = '{1'b0, 5'b00000, 10'b0,              1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0};
    // BODY request while idle: never acked, sticky error
    tv[14] = '{1'b0, 5'b00100, 10'b00_00_00_00_00, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b0};
    tv[15] = '{1'b0, 5'b00000, 10'b0,              1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1};
    tv[16] = '{1'b0, 5'b00000, 10'b0,              1'b1, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1};

    bp_t = '{HD, BD, BD, BD, BD, TL};
    lk_req = '{5'b01010, 5'b01010, 5'b01010, 5'b01010, 5'b01000, 5'b01000};
    lk_ty  = '{10'b00_10_00_10_00, 10'b00_10_00_00_00, 10'b00_10_00_00_00,
               10'b00_10_00_01_00, 10'b00_10_00_00_00, 10'b00_01_00_00_00};
    lk_ack = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b01000, 5'b01000};

    // power-on reset
    reset = 1'b1; i_req = '0; i_flit = '0; i_ds_ack = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    settle();
    chk("rst_ds_req", 64'(o_ds_req), 64'd0);
    chk("rst_ds_flit", 64'(o_ds_flit), 64'd0);
    chk("rst_owner", 64'(o_owner), 64'd0);
    chk("rst_status", 64'(o_port_status), 64'd0);
    chk("rst_occ", 64'(o_occupancy), 64'd0);
    chk("rst_err", 64'(o_proto_err), 64'd0);
    chk("rst_flit_cnt", 64'(o_flit_cnt), 64'd0);
    chk("rst_stall_cnt", 64'(o_stall_cnt), 64'd0);
    tick();

    // directed vector table
    for (int r = 0; r < 17; r++) begin
      drive(tv[r].rst, tv[r].req, tv[r].types, tv[r].ds_ack);
      chk($sformatf("tv%0d_ack", r),    64'(o_ack),       64'(tv[r].exp_ack));
      chk($sformatf("tv%0d_owner", r),  64'(o_owner),     64'(tv[r].exp_owner));
      chk($sformatf("tv%0d_ds_req", r), 64'(o_ds_req),    64'(tv[r].exp_ds_req));
      chk($sformatf("tv%0d_occ", r),    64'(o_occupancy), 64'(tv[r].exp_occ));
      chk($sformatf("tv%0d_err", r),    64'(o_proto_err), 64'(tv[r].exp_err));
      tick();
    end

    // packet lock: input 3 waits for input 1's TAIL
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, lk_req[c], lk_ty[c], 1'b1);
      chk($sformatf("lock%0d_ack", c), 64'(o_ack), 64'(lk_ack[c]));
      tick();
    end
    repeat (3) begin
      drive(1'b0, 5'b0, 10'b0, 1'b1);
      tick();
    end

    // back-pressure: 6-flit packet on input 0 with downstream stalled
    do_reset();
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      drive(1'b0, 5'b00001, {8'b0, bp_t[idx]}, 1'b0);
      if (c < 4) begin
        chk($sformatf("bp%0d_ack", c), 64'(o_ack), 64'd1);
      end else begin
        chk("bp_stall_ack", 64'(o_ack), 64'd0);
        chk("bp_occ", 64'(o_occupancy), 64'd4);
        chk("bp_status", 64'(o_port_status), 64'd2);
        chk("bp_head", 64'(o_ds_flit), 64'(sent[0]));
      end
      if (o_ack[0]) begin
        sent[idx] = i_flit[FLIT_W-1:0];
        idx++;
      end
      tick();
    end
    got.delete();
    for (int c = 0; c < 30 && !(idx == 6 && got.size() == 6); c++) begin
      if (idx < 6) drive(1'b0, 5'b00001, {8'b0, bp_t[idx]}, 1'b1);
      else drive(1'b0, 5'b00000, 10'b0, 1'b1);
      if (o_ds_req) got.push_back(o_ds_flit);
      if (o_ack[0] && idx < 6) begin
        sent[idx] = i_flit[FLIT_W-1:0];
        idx++;
      end
      tick();
    end
    chk("bp_delivered", 64'(got.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) chk($sformatf("bp_order%0d", i), 64'(got[i]), 64'(sent[i]));
    end
    drive(1'b0, 5'b0, 10'b0, 1'b1);
    chk("bp_free", 64'(o_port_status), 64'd0);
    chk("bp_empty", 64'(o_ds_req), 64'd0);
    tick();

    // reset with a locked packet and 3 flits buffered
    do_reset();
    drive(1'b0, 5'b00001, {8'b0, HD}, 1'b0); tick();
    drive(1'b0, 5'b00001, {8'b0, BD}, 1'b0); tick();
    drive(1'b0, 5'b00001, {8'b0, BD}, 1'b0); tick();
    drive(1'b1, 5'b00001, {8'b0, BD}, 1'b0);
    chk("mr_occ_before", 64'(o_occupancy), 64'd3);
    chk("mr_owner_before", 64'(o_owner), 64'd1);
    chk("mr_ack_in_reset", 64'(o_ack), 64'd0);
    tick();
    drive(1'b0, 5'b0, 10'b0, 1'b0);
    chk("mr_ds_req", 64'(o_ds_req), 64'd0);
    chk("mr_occ", 64'(o_occupancy), 64'd0);
    chk("mr_owner", 64'(o_owner), 64'd0);
    chk("mr_flit_cnt", 64'(o_flit_cnt), 64'd0);
    chk("mr_stall_cnt", 64'(o_stall_cnt), 64'd0);
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 63) == 0, 5'($urandom), 10'($urandom),
            $urandom_range(0, 3) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
